// File: rtl/prgram_counter.sv
// Program counter register for the 32-bit MIPS datapath. It holds the fetch address
// and loads the upstream next-PC value on every rising clock edge.
module prgram_counter #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
   parameter bit               FORCE_ALIGN = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] PcIn,
   output logic [WIDTH-1:0] PcNext
);

   logic [WIDTH-1:0] pcLoad_s;

   // Clears the two byte-offset bits so the fetch address is word aligned.
   function automatic logic [WIDTH-1:0] wordAlign(input logic [WIDTH-1:0] pc);
      logic [WIDTH-1:0] aligned;
      aligned      = pc;
      aligned[1:0] = 2'b00;
      return aligned;
   endfunction

   // Selects the value to load: the aligned or the unmodified next-PC.
   always_comb begin
      pcLoad_s = PcIn;
      if (FORCE_ALIGN) begin
         pcLoad_s = wordAlign(PcIn);
      end else begin
         pcLoad_s = PcIn;
      end
   end

   // The PC register. Reset takes effect immediately and wins over any clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PcNext <= RESET_VALUE;
      end else begin
         PcNext <= pcLoad_s;
      end
   end

endmodule

// File: tb/tb_prgram_counter.sv
// Directed bench for prgram_counter: a default instance plus two instances with a
// non-zero reset vector, one with word alignment forced and one without.
module tb_prgram_counter;

   logic        clk;
   logic        rst;
   logic [31:0] pcIn;
   logic [31:0] pcInAlt;
   logic [31:0] pcA;
   logic [31:0] pcB;
   logic [31:0] pcC;

   int assertCount;
   int failCount;

   prgram_counter dutA (
      .clk    (clk),
      .rst    (rst),
      .PcIn   (pcIn),
      .PcNext (pcA)
   );

   prgram_counter #(
      .WIDTH       (32),
      .RESET_VALUE (32'hBFC0_0000),
      .FORCE_ALIGN (1'b1)
   ) dutB (
      .clk    (clk),
      .rst    (rst),
      .PcIn   (pcInAlt),
      .PcNext (pcB)
   );

   prgram_counter #(
      .WIDTH       (32),
      .RESET_VALUE (32'hBFC0_0000),
      .FORCE_ALIGN (1'b0)
   ) dutC (
      .clk    (clk),
      .rst    (rst),
      .PcIn   (pcInAlt),
      .PcNext (pcC)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   logic [31:0] seqA [6];
   logic [31:0] seqB [6];
   logic [31:0] expB [6];

   initial begin
      assertCount = 0;
      failCount   = 0;
      seqA = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0000_0003};
      seqB = '{32'h0000_0007, 32'h1234_5679, 32'hFFFF_FFFF, 32'h0000_0002, 32'h8000_0001, 32'h0000_0010};
      expB = '{32'h0000_0004, 32'h1234_5678, 32'hFFFF_FFFC, 32'h0000_0000, 32'h8000_0000, 32'h0000_0010};

      // Async reset from unknown, before any clock edge.
      rst     = 1'b1;
      pcIn    = 32'h0000_0001;
      pcInAlt = 32'h0000_0007;
      #1;
      check("reset_a", pcA, 32'h0000_0000);
      check("reset_b", pcB, 32'hBFC0_0000);
      check("reset_c", pcC, 32'hBFC0_0000);

      // Release: falling rst does not change the PC.
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("release_a", pcA, 32'h0000_0000);
      check("release_b", pcB, 32'hBFC0_0000);

      // First load after release.
      @(posedge clk);
      #1;
      check("load_a", pcA, 32'h0000_0001);
      check("load_align_b", pcB, 32'h0000_0004);
      check("load_noalign_c", pcC, 32'h0000_0007);

      // PcIn change between edges must not reach the output.
      pcIn = 32'h0000_0020;
      #2;
      check("no_comb_path", pcA, 32'h0000_0001);
      @(negedge clk);
      check("hold_negedge", pcA, 32'h0000_0001);

      // Mid-run async reset with clk low.
      pcIn = 32'h0000_0001;
      #2;
      rst = 1'b1;
      #1;
      check("midrun_reset_a", pcA, 32'h0000_0000);
      check("midrun_reset_b", pcB, 32'hBFC0_0000);
      #2;
      rst = 1'b0;
      #1;
      check("midrun_release", pcA, 32'h0000_0000);
      @(posedge clk);
      #1;
      check("midrun_reload", pcA, 32'h0000_0001);

      // Reset held across a rising edge dominates.
      @(negedge clk);
      rst     = 1'b1;
      pcIn    = 32'hDEAD_BEEC;
      pcInAlt = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      check("reset_dominates_a", pcA, 32'h0000_0000);
      check("reset_dominates_b", pcB, 32'hBFC0_0000);
      check("reset_dominates_c", pcC, 32'hBFC0_0000);
      @(negedge clk);
      rst = 1'b0;

      // Sequential loads, one edge latency, no wrap or saturation.
      for (int i = 0; i < 6; i++) begin
         pcIn    = seqA[i];
         pcInAlt = seqB[i];
         @(posedge clk);
         #1;
         check($sformatf("seq_a[%0d]", i), pcA, seqA[i]);
         check($sformatf("seq_b[%0d]", i), pcB, expB[i]);
         check($sformatf("seq_c[%0d]", i), pcC, seqB[i]);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
